// File: rtl/maxpool2d_seq.sv
// -----------------------------------------------------------------------------
// maxpool2d_seq
//
// Sequential 2-D max-pooling stage that sits behind the conv2d output
// (after bias/activation). A whole flattened multi-channel feature map is
// accepted in one valid/ready handshake. The block then produces one pooled
// element per clock. The complete pooled map is presented to the next layer
// through a second valid/ready handshake.
//
// Element packing (input and output): element e sits at
//   bits [TOTAL-1-e*DW -: DW], where e = ch*W*H + y*W + x,
// so element 0 occupies the most significant DW bits.
//
// Ports
//   clk        in   1                  clock
//   rst_n      in   1                  asynchronous, active-low reset
//   valid_i    in   1                  feature_i holds a frame
//   ready_o    out  1                  block can accept a frame (IDLE)
//   feature_i  in   CHANNEL*IW*IH*DW   signed input map
//   valid_o    out  1                  result_o holds a complete pooled frame
//   ready_i    in   1                  downstream takes result_o
//   result_o   out  CHANNEL*OW*OH*DW   signed pooled map
//
// Timing: valid_o rises N = CHANNEL*OW*OH cycles after the accepting edge.
// With ready_i tied high, one frame is accepted every N+2 cycles.
// -----------------------------------------------------------------------------
module maxpool2d_seq #(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
  parameter int CHANNEL                  = 1,
  parameter int IMAGE_WIDTH              = 26,
  parameter int IMAGE_HEIGHT             = 26,
  parameter int POOL_SIZE                = 2,
  parameter int STRIDE                   = 2,
  localparam int DW       = (IS_BITWIDTH_DOUBLE_SCALE != 0) ? 2 * BITWIDTH : BITWIDTH,
  localparam int OW       = (IMAGE_WIDTH  - POOL_SIZE) / STRIDE + 1,
  localparam int OH       = (IMAGE_HEIGHT - POOL_SIZE) / STRIDE + 1,
  localparam int IN_BITS  = CHANNEL * IMAGE_WIDTH * IMAGE_HEIGHT * DW,
  localparam int OUT_BITS = CHANNEL * OW * OH * DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [IN_BITS-1:0]  feature_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [OUT_BITS-1:0] result_o
);

  localparam int IN_ELEMS  = CHANNEL * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int OUT_ELEMS = CHANNEL * OW * OH;
  localparam int WIN       = POOL_SIZE * POOL_SIZE;

  // Counter widths. They are kept at least 1 bit wide for degenerate shapes.
  localparam int OXW   = (OW > 1)      ? $clog2(OW)      : 1;
  localparam int OYW   = (OH > 1)      ? $clog2(OH)      : 1;
  localparam int CHW   = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int INBW  = (IN_BITS > 1)  ? $clog2(IN_BITS)  : 1;
  localparam int OUTBW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

  // One-hot state encoding. Any other pattern is treated as illegal.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUSY = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [IN_BITS-1:0]   r_feature;
  logic [OUT_BITS-1:0]  r_result;
  logic [OXW-1:0]       r_ox;
  logic [OYW-1:0]       r_oy;
  logic [CHW-1:0]       r_ch;

  logic                 w_accept;
  logic                 w_last_ox;
  logic                 w_last_oy;
  logic                 w_last_ch;
  logic                 w_last;
  logic [31:0]          w_base;   // element index of the window's top-left corner
  logic [31:0]          w_oidx;   // element index of the pooled output
  logic [OUTBW-1:0]     w_olsb;

  logic signed [DW-1:0] w_win [WIN];
  logic signed [DW-1:0] w_max;

  // ---------------------------------------------------------------------------
  // Window addressing
  // ---------------------------------------------------------------------------
  always_comb begin
    w_base = 32'(r_ch) * 32'(IMAGE_WIDTH * IMAGE_HEIGHT)
           + 32'(r_oy) * 32'(STRIDE * IMAGE_WIDTH)
           + 32'(r_ox) * 32'(STRIDE);
    w_oidx = 32'(r_ch) * 32'(OW * OH)
           + 32'(r_oy) * 32'(OW)
           + 32'(r_ox);
    // MSB-first packing: element e starts at LSB (ELEMS-1-e)*DW.
    w_olsb = OUTBW'((32'(OUT_ELEMS - 1) - w_oidx) * 32'(DW));
  end

  // Each window tap has a fixed offset from the corner element. This means
  // only the corner index changes from cycle to cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_win
      localparam int OFF = (gi / POOL_SIZE) * IMAGE_WIDTH + (gi % POOL_SIZE);
      logic [INBW-1:0] w_lsb;
      assign w_lsb     = INBW'((32'(IN_ELEMS - 1) - (w_base + 32'(OFF))) * 32'(DW));
      assign w_win[gi] = r_feature[w_lsb +: DW];
    end
  endgenerate

  // Signed max reduction. A tie keeps the earlier value, which is equal to
  // the later one anyway.
  always_comb begin
    w_max = w_win[0];
    for (int k = 1; k < WIN; k++) begin
      if (w_win[k] > w_max) begin
        w_max = w_win[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------------
  assign w_last_ox = (r_ox == OXW'(OW - 1));
  assign w_last_oy = (r_oy == OYW'(OH - 1));
  assign w_last_ch = (r_ch == CHW'(CHANNEL - 1));
  assign w_last    = w_last_ox & w_last_oy & w_last_ch;
  assign w_accept  = valid_i & ready_o;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: input latch, scan counters and result store
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feature <= '0;
      r_result  <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_ch      <= '0;
    end else if (w_accept) begin
      r_feature <= feature_i;
      r_ox      <= '0;
      r_oy      <= '0;
      r_ch      <= '0;
    end else if (r_state == S_BUSY) begin
      r_result[w_olsb +: DW] <= w_max;
      // Raster order: x fastest, then y, then channel.
      if (w_last_ox) begin
        r_ox <= '0;
        if (w_last_oy) begin
          r_oy <= '0;
          r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
        end else begin
          r_oy <= r_oy + 1'b1;
        end
      end else begin
        r_ox <= r_ox + 1'b1;
      end
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_maxpool2d_seq.sv
// Testbench for maxpool2d_seq.
// dut_a: 1 channel, 4x4 map, 2x2 pooling window, stride 2, DW = 16.
// dut_b: 2 channels, 3x3 map, 2x2 pooling window, stride 1, DW = 16.
module tb_maxpool2d_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         valid_a, ready_a, valid_o_a, ready_i_a;
  logic [255:0] feat_a;
  logic [63:0]  res_a;

  logic         valid_b, ready_b, valid_o_b, ready_i_b;
  logic [287:0] feat_b;
  logic [127:0] res_b;

  int n_total = 0;
  int n_bad   = 0;

  int ramp  [16];
  int pat2  [16];
  int rev   [16];
  int map_b [18];

  logic [255:0] frames_a [3];
  logic [63:0]  exp_a    [3];

  always #5 clk = ~clk;

  maxpool2d_seq #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1), .CHANNEL(1),
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .POOL_SIZE(2), .STRIDE(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_a), .ready_o(ready_a),
    .feature_i(feat_a), .valid_o(valid_o_a), .ready_i(ready_i_a), .result_o(res_a)
  );

  maxpool2d_seq #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1), .CHANNEL(2),
    .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3), .POOL_SIZE(2), .STRIDE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_b), .ready_o(ready_b),
    .feature_i(feat_b), .valid_o(valid_o_b), .ready_i(ready_i_b), .result_o(res_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [255:0] pack_a(input int v[16]);
    logic [255:0] r;
    r = '0;
    for (int e = 0; e < 16; e++) r[(15 - e) * 16 +: 16] = 16'(v[e]);
    return r;
  endfunction

  function automatic logic [287:0] pack_b(input int v[18]);
    logic [287:0] r;
    r = '0;
    for (int e = 0; e < 18; e++) r[(17 - e) * 16 +: 16] = 16'(v[e]);
    return r;
  endfunction

  // Presents one frame to dut_a (which must be idle) and returns 1 time unit
  // after the accepting edge.
  task automatic accept_a(input logic [255:0] f);
    @(negedge clk);
    feat_a  = f;
    valid_a = 1'b1;
    check("a_ready_before_accept", 128'(ready_a), 128'(1));
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    check("a_ready_busy", 128'(ready_a), 128'(0));
  endtask

  // Counts the edges until valid_o_a is seen. The count is bounded.
  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (!valid_o_a && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Keeps ready_i high for one edge so dut_a returns to IDLE.
  task automatic release_a();
    ready_i_a = 1'b1;
    @(posedge clk);
    #1;
    ready_i_a = 1'b0;
    check("a_idle_ready", 128'(ready_a), 128'(1));
    check("a_idle_valid", 128'(valid_o_a), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int cyc, n_acc, n_res, last_acc;

    ramp  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    pat2  = '{-1, -2, -32768, -5, -3, -4, -7, -9, 3, -3, -7, -7, 100, -100, -7, -7};
    rev   = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    map_b = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, -1, -2, -3, -4, -5, -6, -7, -8};
    frames_a[0] = pack_a(ramp);  exp_a[0] = 64'h0005_0007_000D_000F;
    frames_a[1] = pack_a(pat2);  exp_a[1] = 64'hFFFF_FFFB_0064_FFF9;
    frames_a[2] = pack_a(rev);   exp_a[2] = 64'h000F_000D_0007_0005;

    valid_a = 1'b0; ready_i_a = 1'b0; feat_a = '0;
    valid_b = 1'b0; ready_i_b = 1'b0; feat_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready_a), 128'(1));
    check("rst_valid", 128'(valid_o_a), 128'(0));
    check("rst_result", 128'(res_a), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 128'(ready_a), 128'(1));

    // Case 1: ramp input, result appears N=4 cycles after accept
    accept_a(frames_a[0]);
    wait_valid_a(lat);
    check("c1_latency", 128'(lat), 128'(4));
    check("c1_result", 128'(res_a), 128'(exp_a[0]));
    release_a();

    // Case 2: negative windows use a signed compare
    accept_a(frames_a[1]);
    wait_valid_a(lat);
    check("c2_latency", 128'(lat), 128'(4));
    check("c2_result", 128'(res_a), 128'(exp_a[1]));

    // Case 3: back-pressure in DONE; a new valid_i pulse is ignored
    @(negedge clk);
    feat_a  = frames_a[2];
    valid_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    valid_a = 1'b0;
    check("c3_valid_held", 128'(valid_o_a), 128'(1));
    check("c3_result_held", 128'(res_a), 128'(exp_a[1]));
    check("c3_ready_low", 128'(ready_a), 128'(0));
    release_a();
    repeat (2) @(posedge clk);
    #1;
    check("c3_no_queued_frame", 128'(valid_o_a), 128'(0));

    // Case 4: reset asserted on the second BUSY cycle
    accept_a(frames_a[0]);
    @(posedge clk);
    #1;
    check("c4_partial_elem0", 128'(res_a[63:48]), 128'(5));
    rst_n = 1'b0;
    #1;
    check("c4_async_valid", 128'(valid_o_a), 128'(0));
    check("c4_async_ready", 128'(ready_a), 128'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("c4_valid", 128'(valid_o_a), 128'(0));
    check("c4_result", 128'(res_a), 128'(0));
    check("c4_ready", 128'(ready_a), 128'(1));

    // Case 5: two channels, overlapping windows (stride 1), N=8
    @(negedge clk);
    feat_b  = pack_b(map_b);
    valid_b = 1'b1;
    check("c5_ready_before", 128'(ready_b), 128'(1));
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    lat = 0;
    while (!valid_o_b && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("c5_latency", 128'(lat), 128'(8));
    check("c5_result", res_b, 128'h0004_0005_0007_0008_0000_FFFF_FFFD_FFFC);
    ready_i_b = 1'b1;
    @(posedge clk);
    #1;
    ready_i_b = 1'b0;
    check("c5_idle_ready", 128'(ready_b), 128'(1));

    // Case 6: back-to-back frames with valid_i and ready_i held high
    @(negedge clk);
    feat_a    = frames_a[0];
    valid_a   = 1'b1;
    ready_i_a = 1'b1;
    n_acc = 0; n_res = 0; last_acc = 0; cyc = 0;
    while (n_res < 3 && cyc < 100) begin
      if (valid_o_a) begin
        check($sformatf("c6_result%0d", n_res), 128'(res_a), 128'(exp_a[n_res]));
        n_res++;
      end
      if (ready_a) begin
        if (n_acc > 0) check($sformatf("c6_gap%0d", n_acc), 128'(cyc - last_acc), 128'(6));
        last_acc = cyc;
        n_acc++;
      end else begin
        // Switch to the next frame once the current frame has been latched.
        feat_a = frames_a[n_acc % 3];
      end
      if (n_res < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    valid_a = 1'b0;
    check("c6_results_seen", 128'(n_res), 128'(3));
    check("c6_accepts_seen", 128'(n_acc), 128'(3));
    @(posedge clk);
    #1;
    ready_i_a = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
